// File: rtl/motor_sequencer_pkg.sv
// Shared state encodings and default tuning constants for the motor sequencer.
package motor_sequencer_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_RAMP_UP   = 3'd1,
      ST_RUN       = 3'd2,
      ST_RAMP_DOWN = 3'd3,
      ST_COAST     = 3'd4,
      ST_TRIP_WAIT = 3'd5,
      ST_LOCKOUT   = 3'd6
   } state_t;

   localparam int DEF_DUTY_W    = 8;
   localparam int DEF_RAMP_DIV  = 256;
   localparam int DEF_COAST_CYC = 1000;
   localparam int DEF_COOL_CYC  = 5000;
   localparam int DEF_MAX_TRIPS = 3;
   localparam int DEF_CLEAR_CYC = 50000;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b; else m = m;
      if (c > m) m = c; else m = m;
      return m;
   endfunction

endpackage

// File: rtl/motor_sequencer_sync2.sv
// Two-flop synchroniser for asynchronous switch and comparator inputs.
module motor_sequencer_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/motor_sequencer.sv
// Soft-start/stop, reversal dead-time and overcurrent trip/lockout sequencing
// between the user controls and the PWM / H-bridge drive path.
module motor_sequencer
   import motor_sequencer_pkg::*;
#(
   parameter int DUTY_W    = DEF_DUTY_W,
   parameter int RAMP_DIV  = DEF_RAMP_DIV,
   parameter int COAST_CYC = DEF_COAST_CYC,
   parameter int COOL_CYC  = DEF_COOL_CYC,
   parameter int MAX_TRIPS = DEF_MAX_TRIPS,
   parameter int CLEAR_CYC = DEF_CLEAR_CYC
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           run_en,
   input  logic                           dir_req,
   input  logic [DUTY_W-1:0]              duty_tgt,
   input  logic                           over1,
   input  logic                           under750,
   output logic [DUTY_W-1:0]              duty_out,
   output logic                           dir_out,
   output logic                           bridge_en,
   output logic                           fault,
   output logic [$clog2(MAX_TRIPS+1)-1:0] trip_cnt,
   output logic [STATE_W-1:0]             state
);

   localparam int TRIP_W    = $clog2(MAX_TRIPS + 1);
   localparam int SLEW_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int DWELL_MAX = max3(COAST_CYC, COOL_CYC, CLEAR_CYC);
   localparam int DWELL_W   = $clog2(DWELL_MAX + 1);

   localparam logic [SLEW_W-1:0]  SLEW_RELOAD = SLEW_W'(RAMP_DIV - 1);
   localparam logic [SLEW_W-1:0]  SLEW_ONE    = SLEW_W'(1);
   localparam logic [SLEW_W-1:0]  SLEW_ZERO   = SLEW_W'(0);
   localparam logic [DWELL_W-1:0] DWELL_ZERO  = DWELL_W'(0);
   localparam logic [DWELL_W-1:0] DWELL_ONE   = DWELL_W'(1);
   localparam logic [DWELL_W-1:0] DWELL_SAT   = DWELL_W'(DWELL_MAX);
   localparam logic [DWELL_W-1:0] COAST_LAST  = DWELL_W'(COAST_CYC - 1);
   localparam logic [DWELL_W-1:0] COOL_LAST   = DWELL_W'(COOL_CYC - 1);
   localparam logic [DWELL_W-1:0] CLEAR_LAST  = DWELL_W'(CLEAR_CYC - 1);
   localparam logic [TRIP_W-1:0]  TRIP_LIMIT  = TRIP_W'(MAX_TRIPS);
   localparam logic [TRIP_W-1:0]  TRIP_ONE    = TRIP_W'(1);
   localparam logic [TRIP_W-1:0]  TRIP_ZERO   = TRIP_W'(0);
   localparam logic [DUTY_W-1:0]  DUTY_ONE    = DUTY_W'(1);
   localparam logic [DUTY_W-1:0]  DUTY_ZERO   = DUTY_W'(0);

   function automatic logic [DUTY_W-1:0] slew_toward(input logic [DUTY_W-1:0] cur,
                                                     input logic [DUTY_W-1:0] goal);
      logic [DUTY_W-1:0] res;
      if (cur < goal) res = cur + DUTY_ONE;
      else if (cur > goal) res = cur - DUTY_ONE;
      else res = cur;
      return res;
   endfunction

   logic run_s, dir_s, over_s, under_s;
   logic step_s, active_s;
   logic [DUTY_W-1:0]  goal_s, duty_step_s;
   logic [TRIP_W-1:0]  trip_next_s;

   state_t             state_r;
   logic [DUTY_W-1:0]  duty_out_r;
   logic               dir_out_r, bridge_en_r, fault_r;
   logic [TRIP_W-1:0]  trip_cnt_r;
   logic [SLEW_W-1:0]  slew_cnt_r;
   logic [DWELL_W-1:0] dwell_r;

   motor_sequencer_sync2 u_sync_run   (.clk(clk), .rst_n(rst_n), .d(run_en),   .q(run_s));
   motor_sequencer_sync2 u_sync_dir   (.clk(clk), .rst_n(rst_n), .d(dir_req),  .q(dir_s));
   motor_sequencer_sync2 u_sync_over  (.clk(clk), .rst_n(rst_n), .d(over1),    .q(over_s));
   motor_sequencer_sync2 u_sync_under (.clk(clk), .rst_n(rst_n), .d(under750), .q(under_s));

   assign step_s      = (slew_cnt_r == SLEW_ZERO);
   assign trip_next_s = trip_cnt_r + TRIP_ONE;
   assign active_s    = (state_r == ST_RAMP_UP) || (state_r == ST_RUN) || (state_r == ST_RAMP_DOWN);

   // Slew goal and the duty value one step closer to it
   always_comb begin
      goal_s      = duty_tgt;
      duty_step_s = duty_out_r;
      if (state_r == ST_RAMP_DOWN) goal_s = DUTY_ZERO;
      else goal_s = duty_tgt;
      if (step_s) duty_step_s = slew_toward(duty_out_r, goal_s);
      else duty_step_s = duty_out_r;
   end

   // Sequencing FSM; every transition reloads the slew timer and clears the dwell counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         duty_out_r  <= DUTY_ZERO;
         dir_out_r   <= 1'b0;
         bridge_en_r <= 1'b0;
         fault_r     <= 1'b0;
         trip_cnt_r  <= TRIP_ZERO;
         slew_cnt_r  <= SLEW_RELOAD;
         dwell_r     <= DWELL_ZERO;
      end else begin
         slew_cnt_r <= step_s ? SLEW_RELOAD : (slew_cnt_r - SLEW_ONE);
         if (dwell_r != DWELL_SAT) dwell_r <= dwell_r + DWELL_ONE;
         else dwell_r <= dwell_r;

         if (active_s && over_s) begin
            duty_out_r  <= DUTY_ZERO;
            bridge_en_r <= 1'b0;
            trip_cnt_r  <= trip_next_s;
            slew_cnt_r  <= SLEW_RELOAD;
            dwell_r     <= DWELL_ZERO;
            if (trip_next_s == TRIP_LIMIT) begin
               state_r <= ST_LOCKOUT;
               fault_r <= 1'b1;
            end else begin
               state_r <= ST_TRIP_WAIT;
            end
         end else begin
            case (state_r)
               ST_IDLE: begin
                  duty_out_r  <= DUTY_ZERO;
                  bridge_en_r <= 1'b0;
                  if (run_s) begin
                     dir_out_r   <= dir_s;
                     bridge_en_r <= 1'b1;
                     state_r     <= ST_RAMP_UP;
                     slew_cnt_r  <= SLEW_RELOAD;
                     dwell_r     <= DWELL_ZERO;
                  end
               end
               ST_RAMP_UP: begin
                  if (!run_s || (dir_s != dir_out_r)) begin
                     state_r    <= ST_RAMP_DOWN;
                     slew_cnt_r <= SLEW_RELOAD;
                     dwell_r    <= DWELL_ZERO;
                  end else if (duty_out_r == duty_tgt) begin
                     state_r    <= ST_RUN;
                     slew_cnt_r <= SLEW_RELOAD;
                     dwell_r    <= DWELL_ZERO;
                  end else begin
                     duty_out_r <= duty_step_s;
                  end
               end
               ST_RUN: begin
                  if (!run_s || (dir_s != dir_out_r)) begin
                     state_r    <= ST_RAMP_DOWN;
                     slew_cnt_r <= SLEW_RELOAD;
                     dwell_r    <= DWELL_ZERO;
                  end else begin
                     duty_out_r <= duty_step_s;
                     if (dwell_r >= CLEAR_LAST) trip_cnt_r <= TRIP_ZERO;
                  end
               end
               ST_RAMP_DOWN: begin
                  if (duty_out_r == DUTY_ZERO) begin
                     bridge_en_r <= 1'b0;
                     state_r     <= run_s ? ST_COAST : ST_IDLE;
                     slew_cnt_r  <= SLEW_RELOAD;
                     dwell_r     <= DWELL_ZERO;
                  end else if (run_s && (dir_s == dir_out_r)) begin
                     state_r    <= ST_RAMP_UP;
                     slew_cnt_r <= SLEW_RELOAD;
                     dwell_r    <= DWELL_ZERO;
                  end else begin
                     duty_out_r <= duty_step_s;
                  end
               end
               ST_COAST: begin
                  bridge_en_r <= 1'b0;
                  if (dwell_r == COAST_LAST) begin
                     slew_cnt_r <= SLEW_RELOAD;
                     dwell_r    <= DWELL_ZERO;
                     if (run_s) begin
                        dir_out_r   <= dir_s;
                        bridge_en_r <= 1'b1;
                        state_r     <= ST_RAMP_UP;
                     end else begin
                        state_r <= ST_IDLE;
                     end
                  end
               end
               ST_TRIP_WAIT: begin
                  duty_out_r  <= DUTY_ZERO;
                  bridge_en_r <= 1'b0;
                  if ((dwell_r >= COOL_LAST) && under_s) begin
                     slew_cnt_r <= SLEW_RELOAD;
                     dwell_r    <= DWELL_ZERO;
                     if (run_s) begin
                        dir_out_r   <= dir_s;
                        bridge_en_r <= 1'b1;
                        state_r     <= ST_RAMP_UP;
                     end else begin
                        state_r <= ST_IDLE;
                     end
                  end
               end
               ST_LOCKOUT: begin
                  duty_out_r  <= DUTY_ZERO;
                  bridge_en_r <= 1'b0;
                  fault_r     <= 1'b1;
                  if (!run_s) begin
                     state_r    <= ST_IDLE;
                     fault_r    <= 1'b0;
                     trip_cnt_r <= TRIP_ZERO;
                     slew_cnt_r <= SLEW_RELOAD;
                     dwell_r    <= DWELL_ZERO;
                  end
               end
               default: begin
                  state_r     <= ST_IDLE;
                  duty_out_r  <= DUTY_ZERO;
                  bridge_en_r <= 1'b0;
                  fault_r     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign duty_out  = duty_out_r;
   assign dir_out   = dir_out_r;
   assign bridge_en = bridge_en_r;
   assign fault     = fault_r;
   assign trip_cnt  = trip_cnt_r;
   assign state     = state_r;

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed vector table plus hand-written trip, lockout and reset sequences for motor_sequencer.
module tb_motor_sequencer;
   import motor_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run_en, dir_req, over1, under750;
   logic [7:0] duty_tgt;
   logic [7:0] duty_out;
   logic       dir_out, bridge_en, fault;
   logic [1:0] trip_cnt;
   logic [2:0] state;

   int tests  = 0;
   int failed = 0;
   int dir_viol = 0;
   logic prev_ok = 1'b0;
   logic prev_dir = 1'b0;
   logic prev_bridge = 1'b0;

   typedef struct {
      int run; int dir; int tgt; int over; int under; int cyc;
      int duty; int dir_o; int bridge; int fault; int trip; int st;
   } vec_t;

   vec_t vecs[$];

   motor_sequencer #(
      .DUTY_W(8), .RAMP_DIV(2), .COAST_CYC(4), .COOL_CYC(8), .MAX_TRIPS(3), .CLEAR_CYC(20)
   ) dut (
      .clk(clk), .rst_n(rst_n), .run_en(run_en), .dir_req(dir_req), .duty_tgt(duty_tgt),
      .over1(over1), .under750(under750), .duty_out(duty_out), .dir_out(dir_out),
      .bridge_en(bridge_en), .fault(fault), .trip_cnt(trip_cnt), .state(state)
   );

   always #5 clk = ~clk;

   // Direction must never change between two samples that both show the bridge driven
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ok <= 1'b0;
      end else begin
         if (prev_ok && prev_bridge && bridge_en && (dir_out != prev_dir)) dir_viol <= dir_viol + 1;
         prev_dir    <= dir_out;
         prev_bridge <= bridge_en;
         prev_ok     <= 1'b1;
      end
   end

   function automatic vec_t v(input int run, input int dir, input int tgt, input int over,
                              input int under, input int cyc, input int duty, input int dir_o,
                              input int bridge, input int flt, input int trip, input int st);
      vec_t r;
      r.run = run; r.dir = dir; r.tgt = tgt; r.over = over; r.under = under; r.cyc = cyc;
      r.duty = duty; r.dir_o = dir_o; r.bridge = bridge; r.fault = flt; r.trip = trip; r.st = st;
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic wait_state(input int s, input int budget, input string name);
      int n;
      n = 0;
      while ((32'(state) != s) && (n < budget)) begin
         tick(1);
         n++;
      end
      chk(name, 32'(state), s);
   endtask

   task automatic pulse_over();
      over1 = 1'b1;
      tick(3);
      over1 = 1'b0;
   endtask

   task automatic chk_outputs(input string tag, input int duty, input int dir_o, input int bridge,
                              input int flt, input int trip, input int st);
      chk({tag, "_duty"},   32'(duty_out),  duty);
      chk({tag, "_dir"},    32'(dir_out),   dir_o);
      chk({tag, "_bridge"}, 32'(bridge_en), bridge);
      chk({tag, "_fault"},  32'(fault),     flt);
      chk({tag, "_trip"},   32'(trip_cnt),  trip);
      chk({tag, "_state"},  32'(state),     st);
   endtask

   initial begin
      run_en = 1'b0; dir_req = 1'b0; over1 = 1'b0; under750 = 1'b0; duty_tgt = 8'd0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #3 chk_outputs("reset", 0, 0, 0, 0, 0, ST_IDLE);
      #8 rst_n = 1'b1;

      // soft start / stop, Over1 ignored in IDLE
      vecs.push_back(v(0, 0,  0, 0, 0,  2,  0, 0, 0, 0, 0, ST_IDLE));
      vecs.push_back(v(0, 0,  0, 1, 0,  4,  0, 0, 0, 0, 0, ST_IDLE));
      vecs.push_back(v(0, 0,  0, 0, 0,  3,  0, 0, 0, 0, 0, ST_IDLE));
      vecs.push_back(v(1, 0, 10, 0, 0,  3,  0, 0, 1, 0, 0, ST_RAMP_UP));
      vecs.push_back(v(1, 0, 10, 0, 0,  2,  1, 0, 1, 0, 0, ST_RAMP_UP));
      vecs.push_back(v(1, 0, 10, 0, 0,  2,  2, 0, 1, 0, 0, ST_RAMP_UP));
      vecs.push_back(v(1, 0, 10, 0, 0, 16, 10, 0, 1, 0, 0, ST_RAMP_UP));
      vecs.push_back(v(1, 0, 10, 0, 0,  1, 10, 0, 1, 0, 0, ST_RUN));
      vecs.push_back(v(1, 0, 10, 0, 0,  3, 10, 0, 1, 0, 0, ST_RUN));
      vecs.push_back(v(0, 0, 10, 0, 0,  3, 10, 0, 1, 0, 0, ST_RAMP_DOWN));
      vecs.push_back(v(0, 0, 10, 0, 0,  2,  9, 0, 1, 0, 0, ST_RAMP_DOWN));
      vecs.push_back(v(0, 0, 10, 0, 0, 18,  0, 0, 1, 0, 0, ST_RAMP_DOWN));
      vecs.push_back(v(0, 0, 10, 0, 0,  1,  0, 0, 0, 0, 0, ST_IDLE));
      // reversal with a 4-cycle coast
      vecs.push_back(v(1, 0,  6, 0, 0, 16,  6, 0, 1, 0, 0, ST_RUN));
      vecs.push_back(v(1, 1,  6, 0, 0, 15,  0, 0, 1, 0, 0, ST_RAMP_DOWN));
      vecs.push_back(v(1, 1,  6, 0, 0,  1,  0, 0, 0, 0, 0, ST_COAST));
      vecs.push_back(v(1, 1,  6, 0, 0,  3,  0, 0, 0, 0, 0, ST_COAST));
      vecs.push_back(v(1, 1,  6, 0, 0,  1,  0, 1, 1, 0, 0, ST_RAMP_UP));
      vecs.push_back(v(1, 1,  6, 0, 0, 13,  6, 1, 1, 0, 0, ST_RUN));
      vecs.push_back(v(0, 1,  6, 0, 0, 16,  0, 1, 0, 0, 0, ST_IDLE));
      // direction request withdrawn mid ramp-down: back to RAMP_UP without coasting
      vecs.push_back(v(1, 1,  8, 0, 0, 20,  8, 1, 1, 0, 0, ST_RUN));
      vecs.push_back(v(1, 0,  8, 0, 0,  5,  7, 1, 1, 0, 0, ST_RAMP_DOWN));
      vecs.push_back(v(1, 1,  8, 0, 0,  3,  6, 1, 1, 0, 0, ST_RAMP_UP));
      vecs.push_back(v(1, 1,  8, 0, 0,  5,  8, 1, 1, 0, 0, ST_RUN));
      vecs.push_back(v(0, 1,  8, 0, 0, 20,  0, 1, 0, 0, 0, ST_IDLE));

      foreach (vecs[i]) begin
         run_en   = (vecs[i].run != 0);
         dir_req  = (vecs[i].dir != 0);
         duty_tgt = 8'(vecs[i].tgt);
         over1    = (vecs[i].over != 0);
         under750 = (vecs[i].under != 0);
         tick(vecs[i].cyc);
         chk_outputs($sformatf("vec%0d", i), vecs[i].duty, vecs[i].dir_o, vecs[i].bridge,
                     vecs[i].fault, vecs[i].trip, vecs[i].st);
      end

      // trip and retry gated by Under750
      run_en = 1'b1; dir_req = 1'b0; duty_tgt = 8'd4; under750 = 1'b0;
      wait_state(ST_RUN, 30, "t3_reach_run");
      chk("t3_duty", 32'(duty_out), 4);
      chk("t3_dir", 32'(dir_out), 0);
      tick(2);
      pulse_over();
      chk_outputs("t3_trip", 0, 0, 0, 0, 1, ST_TRIP_WAIT);
      tick(20);
      chk("t3_hold_wait", 32'(state), ST_TRIP_WAIT);
      under750 = 1'b1;
      tick(2);
      chk("t3_sync_lat", 32'(state), ST_TRIP_WAIT);
      tick(1);
      chk_outputs("t3_retry", 0, 0, 1, 0, 1, ST_RAMP_UP);

      // lockout after three trips with short runs in between
      wait_state(ST_RUN, 30, "t4_reach_run");
      tick(2);
      pulse_over();
      chk("t4_trip2_cnt", 32'(trip_cnt), 2);
      chk("t4_trip2_state", 32'(state), ST_TRIP_WAIT);
      wait_state(ST_RAMP_UP, 20, "t4_retry");
      pulse_over();
      chk_outputs("t4_lock", 0, 0, 0, 1, 3, ST_LOCKOUT);
      tick(10);
      chk("t4_lock_hold", 32'(state), ST_LOCKOUT);
      chk("t4_lock_fault", 32'(fault), 1);
      run_en = 1'b0;
      tick(2);
      chk("t4_lock_lat", 32'(state), ST_LOCKOUT);
      tick(1);
      chk_outputs("t4_release", 0, 0, 0, 0, 0, ST_IDLE);

      // long RUN clears the trip history
      run_en = 1'b1; duty_tgt = 8'd2;
      for (int k = 0; k < 2; k++) begin
         wait_state(ST_RUN, 30, $sformatf("t5_run%0d", k));
         tick(2);
         pulse_over();
         chk($sformatf("t5_trip%0d_cnt", k), 32'(trip_cnt), k + 1);
         chk($sformatf("t5_trip%0d_state", k), 32'(state), ST_TRIP_WAIT);
      end
      wait_state(ST_RUN, 40, "t5_run_long");
      tick(2);
      chk("t5_before_clear", 32'(trip_cnt), 2);
      tick(23);
      chk("t5_cleared", 32'(trip_cnt), 0);
      chk("t5_still_run", 32'(state), ST_RUN);
      pulse_over();
      chk_outputs("t5_third", 0, 0, 0, 0, 1, ST_TRIP_WAIT);

      // asynchronous reset mid ramp-up
      run_en = 1'b0;
      wait_state(ST_IDLE, 20, "t6_idle");
      chk("t6_trip_kept", 32'(trip_cnt), 1);
      dir_req = 1'b1; run_en = 1'b1; duty_tgt = 8'd5;
      wait_state(ST_RAMP_UP, 10, "t6_ramp");
      tick(3);
      chk("t6_pre_duty", 32'(duty_out), 1);
      chk("t6_pre_dir", 32'(dir_out), 1);
      #3 rst_n = 1'b0;
      #1 chk_outputs("t6_async", 0, 0, 0, 0, 0, ST_IDLE);
      #2 rst_n = 1'b1;
      tick(2);
      chk("t6_restart_lat", 32'(state), ST_IDLE);
      tick(1);
      chk_outputs("t6_restart", 0, 1, 1, 0, 0, ST_RAMP_UP);
      tick(2);
      chk("t6_restart_step", 32'(duty_out), 1);

      chk("dir_while_bridge", 32'(dir_viol), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/motor_sequencer.md
Name: motor_sequencer

Overview:
Sequencing controller that sits between the user controls (run enable, direction switch, duty setpoint) and the PWM generator / H-bridge drive path. It soft-starts and soft-stops the motor by slewing the duty command. It enforces a coast dead-time on direction reversal. It handles overcurrent trips with a cooldown and automatic retry, and latches a lockout fault after repeated trips. Its outputs feed the PWM generator (DUTY_OUT) and the Forward/Backward gating (DIR_OUT, BRIDGE_EN).

Parameters:
DUTY_W, 8, width of duty setpoint/command
RAMP_DIV, 256, clock cycles per 1-LSB duty step while slewing
COAST_CYC, 1000, bridge-off cycles between ramp-down and direction change
COOL_CYC, 5000, minimum bridge-off cycles after an overcurrent trip
MAX_TRIPS, 3, consecutive trips that cause lockout (>=1)
CLEAR_CYC, 50000, continuous RUN cycles that clear the trip count

Ports:
CLK  in  1  system clock, single domain, rising edge
RST_N  in  1  asynchronous active-low reset
RUN_EN  in  1  motor run request (async, switch)
DIR_REQ  in  1  requested direction, 0=forward 1=backward (async, SW7)
DUTY_TGT  in  DUTY_W  duty setpoint (quasi-static)
Over1  in  1  motor current >1 A (async)
Under750  in  1  motor current <750 mA (async)
DUTY_OUT  out  DUTY_W  duty command to PWM generator
DIR_OUT  out  1  applied direction
BRIDGE_EN  out  1  H-bridge drive enable
FAULT  out  1  lockout indicator
TRIP_CNT  out  $clog2(MAX_TRIPS+1)  consecutive trip count
STATE  out  3  current state encoding, for SSEG/debug

Behaviour:
- Input synchronisation:
  - RUN_EN, DIR_REQ, Over1 and Under750 each pass through a 2-flop synchroniser.
  - All decisions use the synchronised values, so latency from pin to decision is 2 cycles.
- Outputs: all registered. Reset values: DUTY_OUT=0, DIR_OUT=0, BRIDGE_EN=0, FAULT=0, TRIP_CNT=0, STATE=IDLE. Synchroniser flops also reset to 0.
- States: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, COAST=4, TRIP_WAIT=5, LOCKOUT=6.
- Slew timer:
  - Free-running down-counter reloaded with RAMP_DIV-1.
  - A step occurs when the counter reaches 0; DUTY_OUT then moves 1 LSB toward its goal.
  - The timer reloads on every state entry.
  - DUTY_OUT never overshoots its goal and never wraps.
- IDLE:
  - BRIDGE_EN=0, DUTY_OUT=0.
  - RUN_EN=1 → load DIR_OUT=DIR_REQ, go to RAMP_UP.
- RAMP_UP:
  - BRIDGE_EN=1; slew toward DUTY_TGT.
  - DUTY_OUT==DUTY_TGT → RUN.
- RUN:
  - BRIDGE_EN=1; DUTY_OUT tracks DUTY_TGT at the slew rate in both directions.
  - DUTY_TGT=0 keeps the block in RUN with duty 0.
  - Counts continuous RUN cycles; reaching CLEAR_CYC clears TRIP_CNT.
- Leaving RAMP_UP or RUN:
  - RUN_EN=0 or DIR_REQ≠DIR_OUT → RAMP_DOWN.
- RAMP_DOWN:
  - BRIDGE_EN=1; slew toward 0.
  - At DUTY_OUT==0: RUN_EN=0 → IDLE; otherwise → COAST.
  - DIR_REQ returning to DIR_OUT mid-ramp with RUN_EN=1 → RAMP_UP, continuing from the current duty (no coast).
- COAST:
  - BRIDGE_EN=0 for exactly COAST_CYC cycles.
  - Then load DIR_OUT=DIR_REQ and go to RAMP_UP if RUN_EN=1, else IDLE.
  - DIR_OUT never changes while BRIDGE_EN=1.
- Overcurrent (priority over everything in RAMP_UP/RUN/RAMP_DOWN):
  - Synced Over1=1 → next cycle DUTY_OUT=0, BRIDGE_EN=0, TRIP_CNT+1.
  - New count == MAX_TRIPS → LOCKOUT; otherwise → TRIP_WAIT.
  - Over1 in IDLE, COAST or TRIP_WAIT is ignored, with no count increment.
- TRIP_WAIT:
  - BRIDGE_EN=0.
  - Exit requires both: ≥COOL_CYC cycles elapsed, and synced Under750=1.
  - Exit goes to RAMP_UP from 0 if RUN_EN=1, else IDLE.
  - TRIP_CNT is kept on exit.
- LOCKOUT:
  - FAULT=1, BRIDGE_EN=0, DUTY_OUT=0.
  - Stays until synced RUN_EN=0, then → IDLE with FAULT=0 and TRIP_CNT=0.
- Priority within a cycle: Over1 > RUN_EN=0 > direction change > target tracking.
- RST_N assertion in any state immediately forces the reset values, independent of CLK. No state is retained.

Decomposition:
- Shared package/header: state encodings, STATE width, default parameter constants.
- One natural sub-module, sync2: a 2-flop synchroniser with async active-low reset, instantiated 4×.
- Slew timer, dwell counter and FSM stay in motor_sequencer.

Test Plan:
Bench parameters: DUTY_W=8, RAMP_DIV=2, COAST_CYC=4, COOL_CYC=8, MAX_TRIPS=3, CLEAR_CYC=20.
1. Soft start/stop: RUN_EN=1, DUTY_TGT=10 → DUTY_OUT steps 0..10, one step per 2 CLK, STATE=RUN. Then RUN_EN=0 → steps to 0, then IDLE, BRIDGE_EN=0.
2. Reversal: in RUN at duty 6, DIR_REQ 0→1 → ramp to 0, BRIDGE_EN=0 for exactly 4 cycles, DIR_OUT=1, ramp back to 6. DIR_OUT is never toggled while BRIDGE_EN=1.
3. Trip/retry: in RUN, pulse Over1 for 3 cycles → BRIDGE_EN=0 within 3 CLK of the rising edge, TRIP_CNT=1. Hold Under750=0 for 20 cycles → stays TRIP_WAIT. Under750=1 → RAMP_UP from 0.
4. Lockout: 3 trips without 20 continuous RUN cycles between them → FAULT=1, STATE=LOCKOUT; RUN_EN toggles high-only have no effect. RUN_EN=0 → IDLE, FAULT=0, TRIP_CNT=0.
5. Trip clearing: 2 trips, then ≥20 continuous RUN cycles → TRIP_CNT=0. A third trip then gives TRIP_WAIT, not LOCKOUT.
6. Async reset: assert RST_N=0 mid-RAMP_UP between clock edges → all outputs at reset values immediately. Release → IDLE; RUN_EN=1 restarts from duty 0.
